// File: rtl/i2c_target_regs_if.sv
// ---------------------------------------------------------------------------
// i2c_target_regs_if
// Bus bundle between an I2C master (or bench) and the i2c_target_regs block.
//   scl_i        bus SCL as seen on the wire
//   sda_i        bus SDA as seen on the wire
//   sda_o        open-drain SDA drive from the target (0 pulls low, 1 releases)
//   reg_wr_valid one-clk strobe for each byte committed to the register file
//   reg_wr_addr  register index of the committed byte
//   reg_wr_data  committed byte
//   busy         target is inside an accepted transfer
// Modports: slave = the target block, master = the bus/fabric side.
// ---------------------------------------------------------------------------
interface i2c_target_regs_if;
  localparam int unsigned DATA_W = 8;

  logic              scl_i;
  logic              sda_i;
  logic              sda_o;
  logic              reg_wr_valid;
  logic [DATA_W-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              busy;

  modport slave (
    input  scl_i, sda_i,
    output sda_o, reg_wr_valid, reg_wr_addr, reg_wr_data, busy
  );

  modport master (
    output scl_i, sda_i,
    input  sda_o, reg_wr_valid, reg_wr_addr, reg_wr_data, busy
  );
endinterface

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
// I2C target with an internal 8-bit register file. Oversamples SCL/SDA on clk,
// decodes START/STOP, address + R/W, register pointer, write and read bytes,
// and answers ACKs / read data on the open-drain SDA drive.
//
// Ports:
//   clk  system oversampling clock (>= 8x SCL rate)
//   rst  asynchronous active-high reset
//   bus  i2c_target_regs_if.slave: scl_i, sda_i, sda_o, reg_wr_valid,
//        reg_wr_addr, reg_wr_data, busy
//
// Parameters: TARGET_ADDR (7-bit address), NUM_REGS (power of 2, 2..256),
//             SYNC_STAGES (>= 2).
// Optional feature: define I2C_TARGET_AUTOINC_EN to auto-increment the
// register pointer after each committed write byte and each ACKed read byte.
// ---------------------------------------------------------------------------
module i2c_target_regs #(
  parameter logic [6:0]  TARGET_ADDR = 7'h08,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  i2c_target_regs_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_p, sda_p;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [7:0]       shreg;
  logic [7:0]       shift_in;
  logic [2:0]       bit_cnt;
  logic [PTR_W-1:0] ptr, ptr_next;
  logic             rw;
  logic             ack_phase;
  logic [7:0]       regs [NUM_REGS];

  logic       sda_q, busy_q, wr_valid_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic       sda_nxt, busy_nxt, wr_valid_nxt;
  logic [7:0] wr_addr_nxt, wr_data_nxt;

  // Synchronizers plus one history flop; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_p    <= scl_sync[SYNC_STAGES-1];
      sda_p    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
  assign shift_in  = {shreg[6:0], sda_s};

`ifdef I2C_TARGET_AUTOINC_EN
  assign ptr_next = ptr + PTR_W'(1);
`else
  assign ptr_next = ptr;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; START/STOP override any bit-level progress.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ST_ADDR;
    end else if (stop_det) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise && bit_cnt == 3'd7)
                   state_nxt = (shift_in[7:1] == TARGET_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (scl_fall && ack_phase)
                       state_nxt = rw ? ST_RDATA : ST_REG;
        ST_REG:       if (scl_rise && bit_cnt == 3'd7) state_nxt = ST_REG_ACK;
        ST_REG_ACK:   if (scl_fall && ack_phase) state_nxt = ST_WDATA;
        ST_WDATA:     if (scl_rise && bit_cnt == 3'd7) state_nxt = ST_WDATA_ACK;
        ST_WDATA_ACK: if (scl_fall && ack_phase) state_nxt = ST_WDATA;
        ST_RDATA:     if (scl_rise && bit_cnt == 3'd7) state_nxt = ST_RDATA_ACK;
        ST_RDATA_ACK: if (scl_rise) state_nxt = sda_s ? ST_WAIT_STOP : ST_RDATA;
        default:      state_nxt = state;
      endcase
    end
  end

  // Output next values; SDA only moves on the clk after an SCL fall.
  always_comb begin
    sda_nxt      = sda_q;
    busy_nxt     = busy_q;
    wr_valid_nxt = 1'b0;
    wr_addr_nxt  = wr_addr_q;
    wr_data_nxt  = wr_data_q;
    if (start_det) begin
      sda_nxt  = 1'b1;
      busy_nxt = 1'b1;
    end else if (stop_det) begin
      sda_nxt  = 1'b1;
      busy_nxt = 1'b0;
    end else begin
      case (state)
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          // First fall asserts ACK; second fall ends it and, for a read,
          // already presents the MSB of the first data byte.
          if (scl_fall) begin
            if (!ack_phase)                    sda_nxt = 1'b0;
            else if (state == ST_ADDR_ACK && rw) sda_nxt = regs[ptr][7];
            else                               sda_nxt = 1'b1;
          end
        end
        ST_WDATA: begin
          if (scl_rise && bit_cnt == 3'd7) begin
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = 8'(ptr);
            wr_data_nxt  = shift_in;
          end
        end
        ST_RDATA:     if (scl_fall) sda_nxt = shreg[3'd7 - bit_cnt];
        ST_RDATA_ACK: if (scl_fall) sda_nxt = 1'b1;
        default:      sda_nxt = 1'b1;
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      sda_q      <= sda_nxt;
      busy_q     <= busy_nxt;
      wr_valid_q <= wr_valid_nxt;
      wr_addr_q  <= wr_addr_nxt;
      wr_data_q  <= wr_data_nxt;
    end
  end

  // Datapath: shift register, bit counter, pointer and register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= 8'h00;
    end else if (start_det || stop_det) begin
      bit_cnt   <= 3'd0;
      ack_phase <= 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rw <= sda_s;
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            ack_phase <= ~ack_phase;
            if (state == ST_ADDR_ACK && ack_phase && rw) shreg <= regs[ptr];
          end
        end
        ST_REG: begin
          if (scl_rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) ptr <= shift_in[PTR_W-1:0];
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              regs[ptr] <= shift_in;
              ptr       <= ptr_next;
            end
          end
        end
        ST_RDATA: if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
        ST_RDATA_ACK: begin
          if (scl_rise && !sda_s) begin
            shreg <= regs[ptr_next];
            ptr   <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_o        = sda_q;
  assign bus.busy         = busy_q;
  assign bus.reg_wr_valid = wr_valid_q;
  assign bus.reg_wr_addr  = wr_addr_q;
  assign bus.reg_wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
// Directed bench for i2c_target_regs: a bit-banged I2C master drives SCL/SDA
// (wired-AND with the target's open-drain drive) and each scenario task
// checks its own expected values.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;

  localparam int unsigned Q = 6;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  int         wr_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic       sda_low_seen = 1'b0;

  i2c_target_regs_if bus ();

  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & bus.sda_o;

  i2c_target_regs #(
    .TARGET_ADDR (7'h08),
    .NUM_REGS    (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Strobe and SDA-drive monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.reg_wr_valid === 1'b1) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = bus.reg_wr_addr;
      last_data = bus.reg_wr_data;
    end
    if (bus.sda_o !== 1'b1) sda_low_seen = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- bit-banged master primitives ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    m_sda = b;    wait_q();
    m_scl = 1'b1; wait_q();
    r = bus.sda_i; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(nack, r);
  endtask

  task automatic write_reg(input logic [7:0] idx, input logic [7:0] d);
    logic a;
    i2c_start();
    write_byte(8'h10, a);
    write_byte(idx, a);
    write_byte(d, a);
    i2c_stop();
  endtask

  task automatic read_reg(input logic [7:0] idx, output logic [7:0] d);
    logic a;
    i2c_start();
    write_byte(8'h10, a);
    write_byte(idx, a);
    i2c_start();
    write_byte(8'h11, a);
    read_byte(1'b1, d);
    i2c_stop();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.sda_o !== 1'b1) begin
      tests_failed++; $display("FAIL reset_sda_o: got %b expected 1", bus.sda_o);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    tests_run++;
    if (bus.reg_wr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_wr_valid: got %b expected 0", bus.reg_wr_valid);
    end
    tests_run++;
    if (bus.reg_wr_addr !== 8'h00 || bus.reg_wr_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_wr_bus: got addr %h data %h expected 00 00", bus.reg_wr_addr, bus.reg_wr_data);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic a1, a2, a3;
    int   cnt0;
    cnt0 = wr_cnt;
    i2c_start();
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++; $display("FAIL write_busy_after_start: got %b expected 1", bus.busy);
    end
    write_byte(8'h10, a1);
    write_byte(8'h05, a2);
    write_byte(8'hAC, a3);
    tests_run++;
    if ({a1, a2, a3} !== 3'b000) begin
      tests_failed++; $display("FAIL write_acks: got %b expected 000", {a1, a2, a3});
    end
    i2c_stop();
    tests_run++;
    if (wr_cnt - cnt0 !== 1) begin
      tests_failed++; $display("FAIL write_strobe_count: got %0d expected 1", wr_cnt - cnt0);
    end
    tests_run++;
    if (last_addr !== 8'h05 || last_data !== 8'hAC) begin
      tests_failed++; $display("FAIL write_strobe_payload: got %h/%h expected 05/ac", last_addr, last_data);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL write_busy_after_stop: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_read();
    logic       a;
    logic [7:0] d;
    write_reg(8'h03, 8'h5A);
    i2c_start();
    write_byte(8'h11, a);
    tests_run++;
    if (a !== 1'b0) begin
      tests_failed++; $display("FAIL read_addr_ack: got %b expected 0", a);
    end
    read_byte(1'b1, d);
    tests_run++;
    if (d !== 8'h5A) begin
      tests_failed++; $display("FAIL read_data: got %h expected 5a", d);
    end
    tests_run++;
    if (bus.sda_o !== 1'b1) begin
      tests_failed++; $display("FAIL read_release_after_nack: got %b expected 1", bus.sda_o);
    end
    i2c_stop();
    // Pointer must still be 3: a plain read returns the same byte again.
    i2c_start();
    write_byte(8'h11, a);
    read_byte(1'b1, d);
    i2c_stop();
    tests_run++;
    if (d !== 8'h5A) begin
      tests_failed++; $display("FAIL read_ptr_retained: got %h expected 5a", d);
    end
  endtask

  task automatic test_addr_mismatch();
    logic       a1, a2;
    logic [7:0] d;
    int         cnt0;
    cnt0 = wr_cnt;
    sda_low_seen = 1'b0;
    i2c_start();
    write_byte(8'h20, a1);
    write_byte(8'h03, a2);
    i2c_stop();
    tests_run++;
    if ({a1, a2} !== 2'b11) begin
      tests_failed++; $display("FAIL mismatch_no_ack: got %b expected 11", {a1, a2});
    end
    tests_run++;
    if (sda_low_seen !== 1'b0) begin
      tests_failed++; $display("FAIL mismatch_sda_driven: got %b expected 0", sda_low_seen);
    end
    tests_run++;
    if (wr_cnt !== cnt0) begin
      tests_failed++; $display("FAIL mismatch_strobe: got %0d expected %0d", wr_cnt, cnt0);
    end
    read_reg(8'h03, d);
    tests_run++;
    if (d !== 8'h5A) begin
      tests_failed++; $display("FAIL mismatch_reg_unchanged: got %h expected 5a", d);
    end
  endtask

  task automatic test_autoinc_wrap();
    logic       a1, a2, a3, a4;
    logic [7:0] d15, d0;
    logic [7:0] exp15, exp0, exp_last;
    int         cnt0;
`ifdef I2C_TARGET_AUTOINC_EN
    exp15 = 8'h11; exp0 = 8'h22; exp_last = 8'h00;
`else
    exp15 = 8'h22; exp0 = 8'h00; exp_last = 8'h0F;
`endif
    cnt0 = wr_cnt;
    i2c_start();
    write_byte(8'h10, a1);
    write_byte(8'h0F, a2);
    write_byte(8'h11, a3);
    write_byte(8'h22, a4);
    i2c_stop();
    tests_run++;
    if ({a1, a2, a3, a4} !== 4'b0000) begin
      tests_failed++; $display("FAIL wrap_acks: got %b expected 0000", {a1, a2, a3, a4});
    end
    tests_run++;
    if (wr_cnt - cnt0 !== 2) begin
      tests_failed++; $display("FAIL wrap_strobe_count: got %0d expected 2", wr_cnt - cnt0);
    end
    tests_run++;
    if (last_addr !== exp_last || last_data !== 8'h22) begin
      tests_failed++;
      $display("FAIL wrap_last_strobe: got %h/%h expected %h/22", last_addr, last_data, exp_last);
    end
    read_reg(8'h0F, d15);
    read_reg(8'h00, d0);
    tests_run++;
    if (d15 !== exp15) begin
      tests_failed++; $display("FAIL wrap_reg15: got %h expected %h", d15, exp15);
    end
    tests_run++;
    if (d0 !== exp0) begin
      tests_failed++; $display("FAIL wrap_reg0: got %h expected %h", d0, exp0);
    end
  endtask

  task automatic test_repeated_start();
    logic       a1, a2, a3;
    logic [7:0] d;
    int         cnt0;
    write_reg(8'h02, 8'h3C);
    cnt0 = wr_cnt;
    i2c_start();
    write_byte(8'h10, a1);
    write_byte(8'h02, a2);
    i2c_start();
    write_byte(8'h11, a3);
    read_byte(1'b1, d);
    i2c_stop();
    tests_run++;
    if ({a1, a2, a3} !== 3'b000) begin
      tests_failed++; $display("FAIL rs_acks: got %b expected 000", {a1, a2, a3});
    end
    tests_run++;
    if (d !== 8'h3C) begin
      tests_failed++; $display("FAIL rs_read_data: got %h expected 3c", d);
    end
    tests_run++;
    if (wr_cnt !== cnt0) begin
      tests_failed++; $display("FAIL rs_no_strobe: got %0d expected %0d", wr_cnt, cnt0);
    end
  endtask

  task automatic test_reset_mid_read();
    logic       a1, a2, a3;
    logic [7:0] d;
    // reg2 holds 0x3C, whose MSB is 0: the target pulls SDA low for bit 7.
    i2c_start();
    write_byte(8'h10, a1);
    write_byte(8'h02, a2);
    i2c_start();
    write_byte(8'h11, a3);
    tests_run++;
    if (bus.sda_o !== 1'b0) begin
      tests_failed++; $display("FAIL midread_driving_zero: got %b expected 0", bus.sda_o);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.sda_o !== 1'b1) begin
      tests_failed++; $display("FAIL midread_async_release: got %b expected 1", bus.sda_o);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL midread_busy: got %b expected 0", bus.busy);
    end
    m_sda = 1'b1;
    m_scl = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.sda_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midread_idle_after_reset: got busy %b sda %b expected 0 1", bus.busy, bus.sda_o);
    end
    read_reg(8'h02, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL midread_reg2_cleared: got %h expected 00", d);
    end
    read_reg(8'h03, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++; $display("FAIL midread_reg3_cleared: got %h expected 00", d);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_mismatch();
    test_autoinc_wrap();
    test_repeated_start();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) with an internal 8-bit register file.
- Sits directly downstream of the I2C master: consumes its SCL and SDA lines and answers on the shared SDA line.
- Decodes START, 7-bit address + R/W, register-pointer byte, write data, read data, ACK/NACK and STOP.
- Exposes a write strobe to fabric so that accepted writes are visible outside the bus.

Parameters:
- TARGET_ADDR, 7'h08, 7-bit address this block answers to.
- NUM_REGS, 16, register-file depth; power of 2, 2..256.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i; must be >=2.

Ports:
- clk  input  1  system oversampling clock; must be >=8x the SCL rate.
- rst  input  1  asynchronous, active-high reset.
- scl_i  input  1  bus SCL, asynchronous to clk.
- sda_i  input  1  bus SDA as seen on the wire, asynchronous to clk.
- sda_o  output  1  open-drain drive: 0 pulls SDA low, 1 releases it.
- reg_wr_valid  output  1  one-clk pulse when a data byte is committed to the register file.
- reg_wr_addr  output  8  register index of the committed byte.
- reg_wr_data  output  8  committed byte.
- busy  output  1  high from an accepted START until STOP or return to IDLE.

Behaviour:
- Reset (async):
  - sda_o=1, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, busy=0.
  - All registers 0, pointer 0, state IDLE.
  - Reset mid-transfer releases SDA immediately.
- Sampling and edge detection:
  - scl_i/sda_i pass through SYNC_STAGES flops; one further flop gives prev values.
  - SCL rise/fall = synced scl vs prev.
  - START = synced SDA 1->0 while SCL high.
  - STOP = synced SDA 0->1 while SCL high.
- Bit timing:
  - Data is sampled on the clk after an SCL rise.
  - sda_o changes only on the clk after an SCL fall.
- Bit counting: 3-bit counter, MSB first, reset to 0 at START and at each byte boundary.
- START or repeated START, in any state: go to ADDR, bit counter=0, sda_o=1, busy=1.
- STOP, in any state: go to IDLE, sda_o=1, busy=0. The pointer is retained.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Address match: go to ADDR_ACK.
    - Address mismatch: go to WAIT_STOP, sda_o stays 1.
  - ADDR_ACK: drive 0 from the SCL fall after bit 8 to the next SCL fall.
    - rw=0: go to REG.
    - rw=1: load the shift register with regs[ptr], go to RDATA.
  - REG: shift 8 bits, then ptr = byte mod NUM_REGS (upper bits ignored), go to REG_ACK (ACK), then WDATA.
  - WDATA: shift 8 bits.
    - On the 8th SCL rise: regs[ptr] = byte; reg_wr_valid pulses 1 clk with addr=ptr, data=byte.
    - Go to WDATA_ACK (ACK), then WDATA again for the next byte.
  - RDATA: drive shift-register MSB first, changing after each SCL fall, then release SDA for the master's ACK bit.
  - RDATA_ACK: sample sda_i on SCL rise.
    - 0 (ACK): load regs[next ptr], go to RDATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: sda_o=1; ignore everything except START/STOP.
- Simultaneous events: START/STOP detection has priority over the bit shift in the same clk.
- Pointer wrap: NUM_REGS-1 -> 0.
- Without an enabled auto-increment ("next ptr" = ptr), every byte goes to or comes from the same register.
- A write byte interrupted by START/STOP before bit 8 is discarded: no strobe, register unchanged.

Optional Feature:
- Macro: I2C_TARGET_AUTOINC_EN.
- Defined:
  - ptr increments by 1 (mod NUM_REGS) after each committed write byte.
  - ptr increments after each read byte that the master ACKs.
- Undefined:
  - ptr changes only via the REG byte.
  - Burst writes overwrite one register; burst reads repeat one register.

Test Plan:
- Write: START, 0x10 (0x08,W), reg 0x05, data 0xAC, STOP -> three ACKs; reg_wr_valid one pulse with addr=5, data=0xAC; busy 1->0 after STOP.
- Read: write reg 3 = 0x5A, then START, 0x11 (0x08,R), master NACK, STOP -> address ACK; target shifts out 0x5A; SDA released after NACK; pointer stays 3.
- Address mismatch: START, 0x20, 8 more bits, STOP -> sda_o stays 1 throughout; no reg_wr_valid; registers unchanged.
- Auto-increment wrap (macro defined): START, 0x10, reg 0x0F, data 0x11, 0x22, STOP -> reg15=0x11, reg0=0x22, two strobes.
- Auto-increment wrap (macro undefined): same sequence -> reg15=0x22, reg0 unchanged.
- Repeated START: START, 0x10, reg 0x02, repeated START, 0x11, read 1 byte, NACK, STOP -> returns reg2 contents; no write strobe.
- Reset mid-read: assert rst while the target is driving a 0 bit -> sda_o=1 asynchronously; state IDLE; registers 0.
